// File: rtl/tdm_demux8_if.sv
// Serial slot input and parallel word output bundle for tdm_demux8.
// The master side drives the link and consumes words; the slave is the receiver.
interface tdm_demux8_if #(
  parameter int N = 8,
  parameter int SEL_W = 3
);
  logic in_bit;
  logic in_valid;
  logic in_sof;
  logic out_ready;
  logic ovr_clr;
  logic [SEL_W-1:0] select;
  logic [N-1:0] data;
  logic out_valid;
  logic overrun;
  logic sync_err;

  modport master (
    output in_bit, in_valid, in_sof, out_ready, ovr_clr,
    input select, data, out_valid, overrun, sync_err
  );

  modport slave (
    input in_bit, in_valid, in_sof, out_ready, ovr_clr,
    output select, data, out_valid, overrun, sync_err
  );
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: receiver for an 8-slot TDM serial link.
// Assembles slot bits into a word behind a one-entry valid/ready register.
module tdm_demux8 #(
  parameter int N = 8,
  parameter int SEL_W = 3
) (
  input logic clk,
  input logic rst_n,
  tdm_demux8_if.slave bus
);
  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t state;
  logic [SEL_W-1:0] sel_q;
  logic [N-1:0] frame_q;
  logic [N-1:0] word;
  logic [N-1:0] data_q;
  logic vld_q;
  logic ovr_q;
  logic err_q;
  logic take;
  logic sof;
  logic done;
  logic consume;
  logic load;

  // Word as it would look with the current bit merged in.
  always_comb begin
    word = frame_q;
    word[sel_q] = bus.in_bit;
  end

  assign take = bus.in_valid & ~bus.in_sof;
  assign sof = bus.in_valid & bus.in_sof;
  assign done = (state == COLLECT) & take
              & (sel_q == SEL_W'(N - 1));
  assign consume = vld_q & bus.out_ready;
  assign load = done & (~vld_q | bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      sel_q <= '0;
      frame_q <= '0;
      data_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        HUNT: begin
          if (sof) begin
            frame_q <= {{(N - 1){1'b0}}, bus.in_bit};
            sel_q <= SEL_W'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (sof) begin
            err_q <= 1'b1;
            frame_q <= {{(N - 1){1'b0}}, bus.in_bit};
            sel_q <= SEL_W'(1);
          end else if (done) begin
            frame_q <= '0;
            sel_q <= '0;
            state <= HUNT;
          end else if (take) begin
            frame_q <= word;
            sel_q <= sel_q + SEL_W'(1);
          end
        end
        default: state <= HUNT;
      endcase

      if (load) begin
        data_q <= word;
        vld_q <= 1'b1;
      end else if (consume) begin
        vld_q <= 1'b0;
      end

      // A new drop beats a simultaneous clear.
      if (done & ~load) begin
        ovr_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.select = sel_q;
  assign bus.data = data_q;
  assign bus.out_valid = vld_q;
  assign bus.overrun = ovr_q;
  assign bus.sync_err = err_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8.
// Words consumed at the output are popped from a scoreboard of expected frames.
module tb_tdm_demux8;
  logic clk;
  logic rst_n;
  int vectors;
  int miscompares;
  logic [7:0] sb[$];

  tdm_demux8_if #(.N(8), .SEL_W(3)) bus ();

  tdm_demux8 #(.N(8), .SEL_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected data=%h required=none", bus.data);
      end else begin
        logic [7:0] exp_w;
        exp_w = sb.pop_front();
        if (bus.data !== exp_w) begin
          miscompares++;
          $display("FAIL sb_data got=%h required=%h", bus.data, exp_w);
        end
      end
    end
  end

  task automatic drive(input logic b, input logic s, input logic v);
    bus.in_bit = b;
    bus.in_sof = s;
    bus.in_valid = v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int k = 0; k < 8; k++) drive(w[k], k == 0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain left=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovr_clr = 1'b0;
    #12;
    vectors++;
    if ({bus.select, bus.data, bus.out_valid, bus.overrun, bus.sync_err}
        !== 14'h0) begin
      miscompares++;
      $display("FAIL reset sel=%0d data=%h v=%b o=%b e=%b required=0",
               bus.select, bus.data, bus.out_valid, bus.overrun,
               bus.sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'h4D;
    bus.out_ready = 1'b1;
    sb.push_back(w);
    for (int k = 0; k < 8; k++) begin
      drive(w[k], k == 0, 1'b1);
      vectors++;
      if (bus.select !== 3'((k + 1) % 8)) begin
        miscompares++;
        $display("FAIL basic_sel k=%0d got=%0d required=%0d",
                 k, bus.select, (k + 1) % 8);
      end
      vectors++;
      if (bus.out_valid !== (k == 7)) begin
        miscompares++;
        $display("FAIL basic_valid k=%0d got=%b required=%b",
                 k, bus.out_valid, k == 7);
      end
    end
    vectors++;
    if (bus.data !== 8'h4D) begin
      miscompares++;
      $display("FAIL basic_data got=%h required=4d", bus.data);
    end
    drive(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse got=%b required=0", bus.out_valid);
    end
    drain("basic");
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    send_frame(8'hA5);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.data !== 8'hA5) begin
      miscompares++;
      $display("FAIL b2b_first v=%b data=%h required=1/a5",
               bus.out_valid, bus.data);
    end
    drive(1'b0, 1'b1, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap got=%b required=0", bus.out_valid);
    end
    for (int k = 1; k < 8; k++) drive(k == 2 || k == 3 || k == 4 || k == 5, 1'b0, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.data !== 8'h3C
        || bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second v=%b data=%h o=%b required=1/3c/0",
               bus.out_valid, bus.data, bus.overrun);
    end
    drain("b2b");
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    sb.push_back(8'hA5);
    send_frame(8'hA5);
    send_frame(8'h3C);
    vectors++;
    if (bus.data !== 8'hA5 || bus.out_valid !== 1'b1
        || bus.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_hold data=%h v=%b o=%b required=a5/1/1",
               bus.data, bus.out_valid, bus.overrun);
    end
    bus.ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovr_clr = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_clr o=%b v=%b required=0/1",
               bus.overrun, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_consume got=%b required=0", bus.out_valid);
    end
    drain("ovr");
  endtask

  task automatic test_sync_err();
    int pulses;
    logic [7:0] w;
    bus.out_ready = 1'b1;
    pulses = 0;
    w = 8'hFF;
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1);
    vectors++;
    if (bus.select !== 3'd4) begin
      miscompares++;
      $display("FAIL sync_sel got=%0d required=4", bus.select);
    end
    sb.push_back(w);
    for (int k = 0; k < 8; k++) begin
      drive(w[k], k == 0, 1'b1);
      if (bus.sync_err === 1'b1) pulses++;
    end
    drive(1'b0, 1'b0, 1'b0);
    if (bus.sync_err === 1'b1) pulses++;
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL sync_pulses got=%0d required=1", pulses);
    end
    drain("sync");
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    bus.out_ready = 1'b1;
    w = 8'h96;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    vectors++;
    if (bus.select !== 3'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_ignore sel=%0d v=%b required=0/0",
               bus.select, bus.out_valid);
    end
    sb.push_back(w);
    for (int k = 0; k < 8; k++) begin
      drive(w[k], k == 0, 1'b1);
      drive(~w[k], 1'b1, 1'b0);
      vectors++;
      if (bus.select !== 3'((k + 1) % 8)) begin
        miscompares++;
        $display("FAIL gap_sel k=%0d got=%0d required=%0d",
                 k, bus.select, (k + 1) % 8);
      end
    end
    drain("gaps");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send_frame(8'h5A);
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b1);
    vectors++;
    if (bus.select !== 3'd5 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre sel=%0d v=%b required=5/1",
               bus.select, bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.select, bus.data, bus.out_valid, bus.overrun, bus.sync_err}
        !== 14'h0) begin
      miscompares++;
      $display("FAIL areset sel=%0d data=%h v=%b o=%b e=%b required=0",
               bus.select, bus.data, bus.out_valid, bus.overrun,
               bus.sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    sb.push_back(8'hC3);
    send_frame(8'hC3);
    vectors++;
    if (bus.data !== 8'hC3 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_post data=%h v=%b required=c3/1",
               bus.data, bus.out_valid);
    end
    drain("areset");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_sync_err();
    test_gaps();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
